pin_bank_ctrl: RTL and testbench

Parametrised, clocked successor to the flat pin vector interface. Provides PIN_NUM independently programmable pins. Each pin can be high-Z/monitor, static drive, timed pulse or periodic toggle, and every pin has a synchronised edge-detect monitor with saturating edge counters. It sits between the testbench pin agent and the DUT pin vector, and is commanded through a single valid/ready command port.

---
 rtl/pin_bank_ctrl.sv | 148 ++++++++++++++
 tb/tb_pin_bank_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pin_bank_ctrl.sv
// Programmable pin bank: per-pin HIZ/DRIVE/PULSE/TOGGLE driver plus
// synchronised edge monitor with saturating edge counters.
module pin_bank_ctrl #(
  parameter int PIN_NUM     = 8,
  parameter int CNT_W       = 16,
  parameter int EDGE_CNT_W  = 8,
  parameter int SYNC_STAGES = 2,
  localparam int PW = (PIN_NUM > 1) ? $clog2(PIN_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [PW-1:0]         cmd_pin,
  input  logic [1:0]            cmd_mode,
  input  logic                  cmd_value,
  input  logic [CNT_W-1:0]      cmd_len,
  output logic [PIN_NUM-1:0]    pins_o,
  output logic [PIN_NUM-1:0]    pins_oe,
  input  logic [PIN_NUM-1:0]    pins_i,
  output logic [PIN_NUM-1:0]    busy,
  output logic [PIN_NUM-1:0]    rise,
  output logic [PIN_NUM-1:0]    fall,
  input  logic [PW-1:0]         cnt_sel,
  input  logic                  cnt_clr,
  output logic [EDGE_CNT_W-1:0] cnt_val
);

  typedef enum logic [1:0] {
    S_HIZ    = 2'd0,
    S_DRIVE  = 2'd1,
    S_PULSE  = 2'd2,
    S_TOGGLE = 2'd3
  } st_t;

  localparam logic [CNT_W-1:0]      ONE  = 1;
  localparam logic [EDGE_CNT_W-1:0] EONE = 1;

  st_t                   r_st    [PIN_NUM];
  st_t                   w_st_n  [PIN_NUM];
  logic [CNT_W-1:0]      r_tmr   [PIN_NUM];
  logic [CNT_W-1:0]      w_tmr_n [PIN_NUM];
  logic [CNT_W-1:0]      r_len   [PIN_NUM];
  logic [CNT_W-1:0]      w_len_n [PIN_NUM];
  logic [EDGE_CNT_W-1:0] r_cnt   [PIN_NUM];
  logic [PIN_NUM-1:0]    r_sync  [SYNC_STAGES];
  logic [PIN_NUM-1:0]    r_o;
  logic [PIN_NUM-1:0]    w_o_n;
  logic [PIN_NUM-1:0]    r_hist;
  logic [PIN_NUM-1:0]    r_rise;
  logic [PIN_NUM-1:0]    r_fall;
  logic [PIN_NUM-1:0]    w_sync;
  logic [CNT_W-1:0]      w_len;
  logic                  w_pin_ok;
  logic                  w_sel_ok;
  logic                  w_acc;

  assign w_pin_ok  = 32'(cmd_pin) < PIN_NUM;
  assign w_sel_ok  = 32'(cnt_sel) < PIN_NUM;
  assign cmd_ready = w_pin_ok ? !busy[cmd_pin] : 1'b1;
  assign w_acc     = cmd_valid && cmd_ready && w_pin_ok;
  assign w_len     = (cmd_len == '0) ? ONE : cmd_len;
  assign w_sync    = r_sync[SYNC_STAGES-1];

  assign pins_o  = r_o;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign cnt_val = w_sel_ok ? r_cnt[cnt_sel] : '0;

  always_comb begin
    pins_oe = '0;
    busy    = '0;
    for (int i = 0; i < PIN_NUM; i++) begin
      pins_oe[i] = r_st[i] != S_HIZ;
      busy[i]    = r_st[i] == S_PULSE;
    end
  end

  // An accepted command overrides the running activity in the same cycle
  always_comb begin
    w_o_n = r_o;
    for (int i = 0; i < PIN_NUM; i++) begin
      w_st_n[i]  = r_st[i];
      w_tmr_n[i] = r_tmr[i];
      w_len_n[i] = r_len[i];
      if (w_acc && 32'(cmd_pin) == i) begin
        w_st_n[i]  = st_t'(cmd_mode);
        w_tmr_n[i] = w_len - ONE;
        w_len_n[i] = w_len;
        if (cmd_mode != 2'd0) w_o_n[i] = cmd_value;
      end else begin
        unique case (r_st[i])
          S_PULSE: begin
            if (r_tmr[i] == '0) begin
              w_o_n[i]  = ~r_o[i];
              w_st_n[i] = S_DRIVE;
            end else begin
              w_tmr_n[i] = r_tmr[i] - ONE;
            end
          end
          S_TOGGLE: begin
            if (r_tmr[i] == '0) begin
              w_o_n[i]   = ~r_o[i];
              w_tmr_n[i] = r_len[i] - ONE;
            end else begin
              w_tmr_n[i] = r_tmr[i] - ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o    <= '0;
      r_hist <= '0;
      r_rise <= '0;
      r_fall <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      for (int i = 0; i < PIN_NUM; i++) begin
        r_st[i]  <= S_HIZ;
        r_tmr[i] <= '0;
        r_len[i] <= ONE;
        r_cnt[i] <= '0;
      end
    end else begin
      r_o       <= w_o_n;
      r_sync[0] <= pins_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= w_sync;
      r_rise <= w_sync & ~r_hist;
      r_fall <= ~w_sync & r_hist;
      for (int i = 0; i < PIN_NUM; i++) begin
        r_st[i]  <= w_st_n[i];
        r_tmr[i] <= w_tmr_n[i];
        r_len[i] <= w_len_n[i];
        // Clear takes priority over a coincident edge
        if (cnt_clr && 32'(cnt_sel) == i)
          r_cnt[i] <= '0;
        else if ((r_rise[i] || r_fall[i]) && r_cnt[i] != '1)
          r_cnt[i] <= r_cnt[i] + EONE;
      end
    end
  end

endmodule

// File: tb/tb_pin_bank_ctrl.sv
// Directed bench for pin_bank_ctrl: pulse, toggle loopback,
// counter saturation/clear, len=0, out-of-range and async reset.
module tb_pin_bank_ctrl;

  localparam int PN = 6;
  localparam int CW = 16;
  localparam int EW = 8;
  localparam int SS = 2;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [PW-1:0] cmd_pin = '0;
  logic [1:0]    cmd_mode = '0;
  logic          cmd_value = 1'b0;
  logic [CW-1:0] cmd_len = '0;
  logic [PN-1:0] pins_o;
  logic [PN-1:0] pins_oe;
  logic [PN-1:0] pins_i;
  logic [PN-1:0] busy;
  logic [PN-1:0] rise;
  logic [PN-1:0] fall;
  logic [PW-1:0] cnt_sel = '0;
  logic          cnt_clr = 1'b0;
  logic [EW-1:0] cnt_val;

  logic          r_loop = 1'b0;
  logic [PN-1:0] r_ext = '0;
  int            n_run = 0;
  int            n_fail = 0;

  assign pins_i = r_loop ? pins_o : r_ext;

  always #5 clk = ~clk;

  pin_bank_ctrl #(
    .PIN_NUM(PN), .CNT_W(CW), .EDGE_CNT_W(EW), .SYNC_STAGES(SS)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pin(cmd_pin), .cmd_mode(cmd_mode),
    .cmd_value(cmd_value), .cmd_len(cmd_len),
    .pins_o(pins_o), .pins_oe(pins_oe), .pins_i(pins_i),
    .busy(busy), .rise(rise), .fall(fall),
    .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_val(cnt_val)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int pin, input int mode,
                      input int val, input int len);
    cmd_valid = 1'b1;
    cmd_pin   = PW'(pin);
    cmd_mode  = 2'(mode);
    cmd_value = 1'(val);
    cmd_len   = CW'(len);
    @(negedge clk);
    check("ready", cmd_ready, 1);
    nxt();
    cmd_valid = 1'b0;
  endtask

  function automatic int lvl(input int j);
    return (j < 1) ? 0 : ((j - 1) / 3) % 2;
  endfunction

  initial begin
    int cnt_exp;
    logic er;
    logic ef;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) nxt();
    @(negedge clk);
    check("rst_oe", pins_oe, 0);
    check("rst_o", pins_o, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    for (int s = 0; s < 8; s++) begin
      cnt_sel = PW'(s);
      @(negedge clk);
      check("rst_cnt", cnt_val, 0);
    end
    nxt();

    // pulse pin 3, len 5
    send(3, 2, 1, 5);
    for (int k = 1; k <= 7; k++) begin
      cmd_valid = (k == 2) || (k == 3);
      cmd_pin   = (k == 2) ? PW'(3) : PW'(4);
      cmd_mode  = 2'd1;
      cmd_value = (k == 3);
      @(negedge clk);
      check("pulse_o", pins_o[3], k <= 5);
      check("pulse_busy", busy[3], k <= 5);
      check("pulse_oe", pins_oe[3], 1);
      if (k == 2) check("ready_busy", cmd_ready, 0);
      if (k == 3) check("ready_other", cmd_ready, 1);
      nxt();
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pin4_o", pins_o[4], 1);
    check("pin4_oe", pins_oe[4], 1);
    nxt();

    // toggle pin 0 looped back
    r_loop  = 1'b1;
    cnt_sel = '0;
    cnt_clr = 1'b1;
    nxt();
    cnt_clr = 1'b0;
    nxt();
    nxt();
    send(0, 3, 0, 3);
    cnt_exp = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      er = (lvl(k - 3) == 1) && (lvl(k - 4) == 0);
      ef = (lvl(k - 3) == 0) && (lvl(k - 4) == 1);
      check("tog_o", pins_o[0], lvl(k));
      check("tog_rise", rise[0], er);
      check("tog_fall", fall[0], ef);
      check("tog_cnt", cnt_val, cnt_exp);
      if (er || ef) cnt_exp++;
      nxt();
    end
    @(negedge clk);
    check("tog_cnt6", cnt_val, 6);
    nxt();
    send(0, 1, 0, 0);
    r_loop = 1'b0;
    r_ext  = '0;
    repeat (4) nxt();

    // saturation on pin 1 via external input
    cnt_sel = PW'(1);
    @(negedge clk);
    check("sat_pre", cnt_val, 0);
    nxt();
    for (int i = 0; i < 300; i++) begin
      r_ext[1] = ~r_ext[1];
      nxt();
    end
    r_ext[1] = ~r_ext[1];
    cnt_clr  = 1'b1;
    @(negedge clk);
    check("sat_255", cnt_val, 255);
    check("clr_edge", rise[1] | fall[1], 1);
    nxt();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_win", cnt_val, 0);
    repeat (6) nxt();
    @(negedge clk);
    check("cnt_tail", cnt_val, 3);
    nxt();

    // len=0 pulse, then out-of-range command
    send(2, 2, 1, 0);
    @(negedge clk);
    check("len0_o1", pins_o[2], 1);
    check("len0_busy1", busy[2], 1);
    nxt();
    @(negedge clk);
    check("len0_o2", pins_o[2], 0);
    check("len0_busy2", busy[2], 0);
    nxt();
    send(6, 1, 1, 7);
    @(negedge clk);
    check("oor_o", pins_o, 6'b010000);
    check("oor_oe", pins_oe, 6'b011101);
    check("oor_busy", busy, 0);
    nxt();
    cnt_sel = PW'(6);
    cnt_clr = 1'b1;
    @(negedge clk);
    check("oor_cnt", cnt_val, 0);
    nxt();
    cnt_clr = 1'b0;
    cnt_sel = PW'(1);
    @(negedge clk);
    check("oor_noclr", cnt_val, 3);
    nxt();

    // async reset mid-activity
    send(5, 3, 1, 2);
    send(3, 2, 1, 10);
    repeat (3) nxt();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_o", pins_o, 0);
    check("arst_oe", pins_oe, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt", cnt_val, 0);
    nxt();
    rst_n   = 1'b1;
    cmd_pin = PW'(3);
    @(negedge clk);
    check("arst_ready", cmd_ready, 1);
    nxt();
    send(5, 2, 1, 2);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("post_o", pins_o[5], k <= 2);
      check("post_busy", busy[5], k <= 2);
      nxt();
    end
    @(negedge clk);
    check("post_oe", pins_oe, 6'b100000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
